// File: rtl/register_file.sv
// 32-entry MIPS register file: two combinational read ports, one write port, r0 hardwired to 0,
// plus a valid/ready dump sequencer streaming every register to the debug unit. Optional: WRITE_BYPASS_EN.
module register_file #(
  parameter int NBITS = 32,
  parameter int RBITS = 5,
  parameter int NREGS = 32   // must equal 2**RBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RBITS-1:0] reg_rs,
  input  logic [RBITS-1:0] reg_rt,
  output logic [NBITS-1:0] rd_data_a,
  output logic [NBITS-1:0] rd_data_b,
  input  logic             wr_en,
  input  logic [RBITS-1:0] wr_reg,
  input  logic [NBITS-1:0] wr_data,
  input  logic             dump_start,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [NBITS-1:0] dump_data,
  output logic [RBITS-1:0] dump_idx,
  output logic             dump_busy,
  output logic             dump_done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [RBITS-1:0] idx_q, idx_d;
  logic [NBITS-1:0] regs_q [NREGS];
  logic [NBITS-1:0] stored_a, stored_b;
  logic             last_idx;

  // Entry 0 is cleared by reset and never written, so it stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en && (wr_reg != '0)) begin
      regs_q[wr_reg] <= wr_data;
    end
  end

  always_comb begin
    stored_a = (reg_rs == '0) ? '0 : regs_q[reg_rs];
    stored_b = (reg_rt == '0) ? '0 : regs_q[reg_rt];
`ifdef WRITE_BYPASS_EN
    rd_data_a = (wr_en && (wr_reg == reg_rs) && (reg_rs != '0)) ? wr_data : stored_a;
    rd_data_b = (wr_en && (wr_reg == reg_rt) && (reg_rt != '0)) ? wr_data : stored_b;
`else
    rd_data_a = stored_a;
    rd_data_b = stored_b;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign last_idx = (idx_q == RBITS'(NREGS - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          state_d = S_SEND;
          idx_d   = '0;
        end
      end
      S_SEND: begin
        if (dump_ready) begin
          if (last_idx) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Dump path reads stored contents only, never the write bypass.
  always_comb begin
    dump_valid = (state_q == S_SEND);
    dump_busy  = (state_q == S_SEND) || (state_q == S_DONE);
    dump_done  = (state_q == S_DONE);
    dump_idx   = idx_q;
    dump_data  = (state_q == S_SEND) ? regs_q[idx_q] : '0;
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: read/write vector table, plus scoreboarded dump sequences.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  reg_rs, reg_rt, wr_reg;
  logic [31:0] rd_data_a, rd_data_b, wr_data, dump_data;
  logic        wr_en, dump_start, dump_valid, dump_ready, dump_busy, dump_done;
  logic [4:0]  dump_idx;

  always #5 clk = ~clk;

  register_file dut (
    .clk(clk), .rst_n(rst_n),
    .reg_rs(reg_rs), .reg_rt(reg_rt),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_idx(dump_idx),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[10];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;
`ifdef WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
  endtask

  task automatic preload(input logic [31:0] base, input logic [31:0] mul);
    for (int i = 1; i < 32; i++) begin
      wr_en   = 1'b1;
      wr_reg  = 5'(i);
      wr_data = base + mul * 32'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Scoreboard: every handshake seen on the falling edge is the word captured at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) begin
          chk("dump_unexpected_xfer", 32'(dump_idx), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("dump_idx", 32'(dump_idx), 32'(e.idx));
          chk("dump_data", dump_data, e.data);
        end
        xfer_cnt++;
      end
      if (dump_done) done_cnt++;
    end
  end

  initial begin
    int   seen;
    int   stalled;
    int   busy_cycles;
    int   done_before;
    logic [31:0] ea, eb;

    rst_n = 1'b0; reg_rs = '0; reg_rt = '0; wr_en = 1'b0; wr_reg = '0; wr_data = '0;
    dump_start = 1'b0; dump_ready = 1'b0;

    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_busy", 32'(dump_busy), 32'd0);
    chk("rst_done", 32'(dump_done), 32'd0);
    chk("rst_idx", 32'(dump_idx), 32'd0);
    chk("rst_data", dump_data, 32'd0);

    // Populate some state, then reset asynchronously mid-cycle.
    wr_en = 1'b1; wr_reg = 5'd3; wr_data = 32'h1111_0003; tick();
    wr_reg = 5'd5; wr_data = 32'h1111_0005; tick();
    wr_en = 1'b0;
    reg_rs = 5'd3; #1;
    chk("pre_reset_read", rd_data_a, 32'h1111_0003);
    rst_n = 1'b0; #2;
    chk("async_reset_read", rd_data_a, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      reg_rs = 5'(i);
      reg_rt = 5'(31 - i);
      #1;
      chk("post_reset_a", rd_data_a, 32'd0);
      chk("post_reset_b", rd_data_b, 32'd0);
    end

    // ea/eb hold stored-value expectations; bypass adjustment applied below.
    vecs[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0, 5'd0,  32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd5,  32'h12345678, 5'd0, 5'd0,  32'h0,        32'h0};
    vecs[2] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd5, 5'd0,  32'h12345678, 32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd5, 5'd31, 32'h12345678, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7, 5'd5,  32'h0,        32'h12345678};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd7, 5'd0,  32'hA5A5A5A5, 32'h0};
    vecs[6] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0};
    vecs[7] = '{1'b0, 5'd7,  32'h0,        5'd7, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[8] = '{1'b1, 5'd9,  32'h11112222, 5'd3, 5'd9,  32'h0,        32'h0};
    vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd9, 5'd31, 32'h11112222, 32'hCAFEF00D};

    for (int k = 0; k < 10; k++) begin
      wr_en = vecs[k].we; wr_reg = vecs[k].wa; wr_data = vecs[k].wd;
      reg_rs = vecs[k].rs; reg_rt = vecs[k].rt;
      ea = vecs[k].ea; eb = vecs[k].eb;
      if (BYP && vecs[k].we && vecs[k].wa == vecs[k].rs && vecs[k].rs != 5'd0) ea = vecs[k].wd;
      if (BYP && vecs[k].we && vecs[k].wa == vecs[k].rt && vecs[k].rt != 5'd0) eb = vecs[k].wd;
      #2;
      chk($sformatf("vec%0d_a", k), rd_data_a, ea);
      chk($sformatf("vec%0d_b", k), rd_data_b, eb);
      tick();
    end
    wr_en = 1'b0;

    // Dump 1: random backpressure, stray starts, and a write while stalled at index 10.
    preload(32'd0, 32'd4);
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back('{idx: 5'(i), data: (i == 10) ? 32'h0BADF00D : 32'(i * 4)});
    end
    pulse_start();
    seen = 0; stalled = 0;
    for (int c = 0; c < 600 && seen == 0; c++) begin
      wr_en = 1'b0;
      dump_start = 1'b0;
      if ((c == 5 || c == 40) && dump_valid) dump_start = 1'b1;
      if (dump_valid && dump_idx == 5'd10 && stalled == 0) begin
        dump_ready = 1'b0;
        wr_en = 1'b1; wr_reg = 5'd10; wr_data = 32'h0BADF00D;
        stalled = 1;
      end else begin
        dump_ready = 1'($urandom_range(0, 1));
      end
      #2;
      if (dump_done) begin
        seen = 1;
        chk("done_busy", 32'(dump_busy), 32'd1);
        chk("done_valid", 32'(dump_valid), 32'd0);
      end
      tick();
    end
    wr_en = 1'b0; dump_start = 1'b0;
    chk("dump1_finished", 32'(seen), 32'd1);
    #1;
    chk("after_done_busy", 32'(dump_busy), 32'd0);
    chk("after_done_pulse", 32'(dump_done), 32'd0);
    chk("dump1_xfers", 32'(xfer_cnt), 32'd32);
    chk("dump1_done_cnt", 32'(done_cnt), 32'd1);
    chk("dump1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Dump 2: ready held high, reset dropped at index 17.
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back('{idx: 5'(i), data: (i == 10) ? 32'h0BADF00D : 32'(i * 4)});
    end
    dump_ready = 1'b1;
    tick();
    pulse_start();
    done_before = done_cnt;
    seen = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      if (dump_idx == 5'd17) begin
        seen = 1;
        rst_n = 1'b0;
        #2;
        chk("abort_valid", 32'(dump_valid), 32'd0);
        chk("abort_busy", 32'(dump_busy), 32'd0);
        chk("abort_idx", 32'(dump_idx), 32'd0);
        chk("abort_done", 32'(dump_done), 32'd0);
      end else begin
        tick();
      end
    end
    chk("abort_reached_17", 32'(seen), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'(done_before));
    reg_rs = 5'd12; #1;
    chk("abort_regs_cleared", rd_data_a, 32'd0);

    // Dump 3: restart after reset, ready high, length must be 32 transfers + 1 DONE.
    preload(32'h5A00_0000, 32'd3);
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back('{idx: 5'(i), data: (i == 0) ? 32'd0 : 32'h5A00_0000 + 32'(i * 3)});
    end
    dump_ready = 1'b1;
    done_before = done_cnt;
    pulse_start();
    busy_cycles = 0; seen = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      #2;
      if (dump_busy) busy_cycles++;
      if (dump_done) seen = 1;
      tick();
    end
    chk("dump3_finished", 32'(seen), 32'd1);
    chk("dump3_busy_cycles", 32'(busy_cycles), 32'd33);
    chk("dump3_done_cnt", 32'(done_cnt - done_before), 32'd1);
    chk("dump3_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry general-purpose register file for the MIPS pipeline.
- Sits at the decode stage, with two combinational read ports (rs, rt).
- Written at write-back through the address chosen by the register-destination mux (rt / r31 / rd).
- Has a handshaked dump sequencer that streams all registers, one per transfer, to the debug unit (UART path).

Parameters:
- NBITS, 32, data width of each register.
- RBITS, 5, register address width.
- NREGS, 32, number of registers; must equal 2**RBITS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- reg_rs  input  RBITS  read address, port A.
- reg_rt  input  RBITS  read address, port B.
- rd_data_a  output  NBITS  contents of reg_rs.
- rd_data_b  output  NBITS  contents of reg_rt.
- wr_en  input  1  write enable from write-back.
- wr_reg  input  RBITS  write address; output of the destination mux.
- wr_data  input  NBITS  write-back data.
- dump_start  input  1  request a full register dump; sampled only in IDLE.
- dump_valid  output  1  dump_data/dump_idx valid.
- dump_ready  input  1  debug unit accepts the current word.
- dump_data  output  NBITS  register value being dumped.
- dump_idx  output  RBITS  index of the register being dumped.
- dump_busy  output  1  high in SEND and DONE.
- dump_done  output  1  one-cycle pulse after the last transfer.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all registers cleared to 0.
  - FSM goes to IDLE and dump_idx to 0.
  - dump_valid, dump_busy and dump_done go to 0.
  - dump_data reads 0.
- Register 0:
  - hardwired to 0; writes with wr_reg=0 are discarded.
  - reads of address 0 always return 0, with or without bypass.
- Write: on a rising clk with wr_en=1 and wr_reg!=0, regs[wr_reg] <= wr_data.
- Reads: combinational, zero latency, independent of FSM state.
- Dump FSM states:
  - IDLE:
    - dump_valid=0, dump_busy=0.
    - dump_start=1 -> go to SEND with dump_idx=0.
  - SEND:
    - dump_valid=1, dump_busy=1, dump_data = regs[dump_idx] (stored value, no bypass).
    - A transfer occurs on a rising edge with dump_valid&&dump_ready.
    - On transfer with dump_idx<NREGS-1: dump_idx increments.
    - On transfer with dump_idx==NREGS-1: go to DONE; dump_idx wraps to 0.
    - With dump_ready=0: dump_idx and dump_valid hold, and dump_data tracks the stored register.
  - DONE: dump_done=1, dump_busy=1, dump_valid=0 for exactly one cycle, then IDLE.
- dump_start while busy is ignored; it is not queued.
- Writes are accepted in every FSM state.
  - A write to the register currently presented in SEND updates dump_data from the next cycle.
  - The value captured is whatever is on dump_data at the transfer edge.
- Reset asserted mid-dump aborts the dump immediately; no dump_done pulse is produced.
- Total dump length with dump_ready held high: NREGS transfer cycles plus 1 DONE cycle.

Optional Feature:
- Macro: WRITE_BYPASS_EN.
- When defined, each read port is forwarded from the write port: if wr_en=1 and wr_reg==reg_rs and reg_rs!=0, then rd_data_a=wr_data in the same cycle. Port B (reg_rt) is forwarded the same way.
  - This resolves the same-cycle write-back/decode hazard.
- When undefined, reads return only stored contents; a write becomes visible on the cycle after the edge.
- The dump path never uses the bypass.

Test Plan:
- Reset and zero register:
  - Stimulus: assert rst_n=0 mid-operation, release, then read all 32 addresses on both ports. Response: all reads 0.
  - Stimulus: write wr_reg=0, wr_data=32'hDEADBEEF. Response: reg 0 still reads 0.
- Basic write/read:
  - Stimulus: write reg 5=32'h12345678 and reg 31=32'hCAFEF00D (r31 as selected for JAL); on the next cycle set reg_rs=5, reg_rt=31.
  - Response: rd_data_a=32'h12345678, rd_data_b=32'hCAFEF00D.
- Bypass:
  - Stimulus: wr_en=1, wr_reg=7, wr_data=32'hA5A5A5A5, with reg_rs=7 in the same cycle.
  - Response with WRITE_BYPASS_EN: rd_data_a=32'hA5A5A5A5 immediately.
  - Response without it: rd_data_a=old value until after the edge.
- Full dump with backpressure:
  - Setup: preload regs[i]=i*4. Stimulus: pulse dump_start and toggle dump_ready randomly.
  - Response: exactly 32 transfers with dump_idx 0..31 in order and dump_data=idx*4 at each transfer; then one dump_done pulse, after which dump_busy falls.
- Collisions:
  - Stimulus: pulse dump_start during a dump. Response: ignored, and the sequence is unchanged.
  - Stimulus: while stalled at dump_idx=10, write reg 10=32'h0BADF00D. Response: the transferred word is 32'h0BADF00D.
- Reset mid-dump:
  - Stimulus: drop rst_n at dump_idx=17. Response: dump_valid and dump_busy fall at once, no dump_done, dump_idx=0.
  - Stimulus: a new dump_start after reset. Response: the dump restarts at index 0.
